// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// default RAM geometry and requester port indices.
package ram_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_DATA_WIDTH = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a CPU
// port and a loader/DMA port; one transaction in flight at a time.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  arb_state_e state, next_state;
  // Port owning the current transaction; once it completes this is also the
  // "last granted" port that round-robin steers away from.
  logic grant;
  logic pick;

  assign pick = req1 & (~req0 | (grant == PORT_CPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ram_write_enable is only ever high in ACCESS, so it doubles as the write flag there.
  always_comb begin
    next_state = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:      if (req0 || req1) next_state = ACCESS;
      ACCESS:    next_state = ram_write_enable ? DONE : READ_WAIT;
      READ_WAIT: next_state = DONE;
      DONE: begin
        next_state = IDLE;
        ack0       = (grant == PORT_CPU);
        ack1       = (grant == PORT_DMA);
      end
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant            <= PORT_DMA;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant            <= pick;
            ram_address      <= pick ? addr1 : addr0;
            ram_data_in      <= pick ? wdata1 : wdata0;
            ram_write_enable <= pick ? we1 : we0;
          end
        end
        ACCESS: ram_write_enable <= 1'b0;
        READ_WAIT: begin
          if (grant == PORT_DMA) rdata1 <= ram_data_out;
          else                   rdata0 <= ram_data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM alongside the DUT and a
// transaction-level model (memory map, round-robin rule, fixed latencies).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [10:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, ram_write_enable;
  logic [15:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [10:0] ram_address;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:2047];
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rdata [2];
  logic        last_grant;
  logic        req_we [2];
  logic [10:0] req_addr [2];
  logic [15:0] req_data [2];
  logic [10:0] written [$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  // Synchronous single-port RAM: registered read, output frozen during writes.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else                  ram_data_out     <= mem[ram_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [10:0] addr, input logic [15:0] data);
    req_we[port]   = we;
    req_addr[port] = addr;
    req_data[port] = data;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
  endtask

  function automatic logic [15:0] read_ref(input logic [10:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic predict_grant(input bit p0, input bit p1, input logic last);
    if (p0 && p1) return ~last;
    return p1 ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    last_grant   = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // Serve every raised request, checking grant order, latency, write pulse and read data.
  task automatic runTransfers();
    bit   pending [2];
    logic g;
    int   edges, lat, we_count;
    pending[0] = req0;
    pending[1] = req1;
    g        = predict_grant(pending[0], pending[1], last_grant);
    lat      = req_we[g] ? 2 : 3;
    edges    = 0;
    we_count = 0;
    while (pending[0] || pending[1]) begin
      @(posedge clk); #1;
      edges++;
      if (ram_write_enable) begin
        we_count++;
        checkOutput("we_addr", 32'(ram_address), 32'(req_addr[g]));
        checkOutput("we_data", 32'(ram_data_in), 32'(req_data[g]));
      end
      if (ack0 || ack1 || edges > lat + 1) begin
        checkOutput("ack_latency", edges, lat);
        checkOutput("ack0", 32'(ack0), 32'(g == 1'b0));
        checkOutput("ack1", 32'(ack1), 32'(g == 1'b1));
        checkOutput("busy_done", 32'(busy), 32'd1);
        checkOutput("we_pulses", we_count, 32'(req_we[g]));
        if (req_we[g]) begin
          ref_mem[int'(req_addr[g])] = req_data[g];
          written.push_back(req_addr[g]);
        end else begin
          exp_rdata[g] = read_ref(req_addr[g]);
        end
        checkOutput("rdata0", 32'(rdata0), 32'(exp_rdata[0]));
        checkOutput("rdata1", 32'(rdata1), 32'(exp_rdata[1]));
        last_grant = g;
        pending[g] = 1'b0;
        if (g == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        if (pending[0] || pending[1]) begin
          g        = predict_grant(pending[0], pending[1], last_grant);
          lat      = 1 + (req_we[g] ? 2 : 3);
          edges    = 0;
          we_count = 0;
        end
      end
    end
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_acks", 32'({ack0, ack1}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    model_reset();

    // Reset state
    reset = 1'b1;
    #1;
    checkOutput("rst_ack0", 32'(ack0), 32'd0);
    checkOutput("rst_ack1", 32'(ack1), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_we", 32'(ram_write_enable), 32'd0);
    checkOutput("rst_addr", 32'(ram_address), 32'd0);
    checkOutput("rst_din", 32'(ram_data_in), 32'd0);
    checkOutput("rst_rdata0", 32'(rdata0), 32'd0);
    checkOutput("rst_rdata1", 32'(rdata1), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] write 0xBEEF to 0x123 on CPU port, read back on DMA port");
    applyStimulus(0, 1'b1, 11'h123, 16'hBEEF);
    runTransfers();
    applyStimulus(1, 1'b0, 11'h123, 16'h0000);
    runTransfers();
    checkOutput("readback_beef", 32'(rdata1), 32'h0000BEEF);

    $display("[TB] contention after reset");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 1'b1, 11'(12'h200 + r), 16'(16'h1000 + r));
      applyStimulus(1, 1'b0, 11'h123, 16'h0000);
      runTransfers();
    end

    $display("[TB] address range boundaries");
    applyStimulus(0, 1'b1, 11'h7FF, 16'hA5A5);
    runTransfers();
    applyStimulus(1, 1'b1, 11'h000, 16'h5A5A);
    runTransfers();
    applyStimulus(0, 1'b0, 11'h000, 16'h0000);
    applyStimulus(1, 1'b0, 11'h7FF, 16'h0000);
    runTransfers();
    checkOutput("bound_lo", 32'(rdata0), 32'h00005A5A);
    checkOutput("bound_hi", 32'(rdata1), 32'h0000A5A5);

    $display("[TB] reset during READ_WAIT");
    applyStimulus(0, 1'b0, 11'h7FF, 16'h0000);
    @(posedge clk); #1;
    checkOutput("abort_busy_access", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("abort_no_ack_early", 32'({ack0, ack1}), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_we", 32'(ram_write_enable), 32'd0);
    checkOutput("abort_acks", 32'({ack0, ack1}), 32'd0);
    checkOutput("abort_rdata0", 32'(rdata0), 32'd0);
    req0 = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort_quiet", 32'({ack0, ack1, busy}), 32'd0);
    end
    applyStimulus(1, 1'b0, 11'h7FF, 16'h0000);
    runTransfers();

    $display("[TB] randomized traffic");
    for (int t = 0; t < 24; t++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          logic        we;
          logic [10:0] a;
          we = 1'($urandom_range(0, 1));
          if (!we && written.size() > 0 && $urandom_range(0, 3) != 0)
            a = written[$urandom_range(0, written.size() - 1)];
          else
            a = 11'($urandom_range(0, 2047));
          applyStimulus(p, we, a, 16'($urandom));
        end
      end
      runTransfers();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 11, RAM word-address width (2048 words).
REQ-002 SHALL provide parameter DATA_WIDTH, default 16, RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  per-requester access request (port 0 = CPU, port 1 = loader/DMA).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, valid while reqN high.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_WIDTH  and wdata0/wdata1  input  DATA_WIDTH, valid while reqN high.
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per requester.
REQ-009 SHALL have ports rdata0/rdata1  output  DATA_WIDTH  read data, valid in the ackN cycle of a read.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports ram_address  output  ADDR_WIDTH, ram_data_in  output  DATA_WIDTH, ram_write_enable  output  1, ram_data_out  input  DATA_WIDTH, connecting to a synchronous single-port RAM (1-cycle registered read, data_out not updated during a write).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, READ_WAIT, DONE.
REQ-013 IDLE: at an edge with any reqN high, SHALL latch winner index, register ram_address/ram_data_in/ram_write_enable from that port, and enter ACCESS.
REQ-014 Arbitration SHALL be round-robin: with both requests high, grant the port not granted last; a lone requester SHALL win every time.
REQ-015 ACCESS: ram_write_enable SHALL be high for exactly this one cycle on writes; next state DONE for write, READ_WAIT for read.
REQ-016 READ_WAIT: SHALL capture ram_data_out into rdataN of the granted port; next state DONE.
REQ-017 DONE: ackN of the granted port SHALL be high for exactly this cycle; other ack low; next state IDLE.
REQ-018 Latency from the edge sampling reqN to the ack cycle SHALL be 2 cycles for writes and 3 cycles for reads.
REQ-019 Requester SHALL hold req/we/addr/wdata stable until ack and drop req in the cycle after ack; arbiter SHALL not sample requests in ACCESS, READ_WAIT or DONE.
REQ-020 rdataN SHALL hold its last captured value until the next read completes on that port; writes SHALL not modify rdataN.
REQ-021 ram_write_enable SHALL be low in every state except ACCESS-for-write; ram_address SHALL hold its last value outside ACCESS.
REQ-022 Address SHALL pass unmodified (no wrap logic); full range 0..2^ADDR_WIDTH-1 is legal.

Reset
REQ-023 Asserting reset SHALL immediately force state IDLE, ack0/ack1/busy/ram_write_enable = 0, ram_address/ram_data_in/rdata0/rdata1 = 0, last-grant = port 1 (so port 0 wins the first tie).
REQ-024 Reset mid-transaction SHALL abort it with no ack; an aborted write may or may not have reached RAM.

Structure
REQ-025 Shared package/include SHALL hold state encodings (2 bits), ADDR_WIDTH/DATA_WIDTH defaults and port indices PORT_CPU=0, PORT_DMA=1.
REQ-026 Block SHALL be a single module with no sub-modules; the RAM is instantiated alongside it, not inside.

Verification
REQ-027 Write: req0=1, we0=1, addr0=0x123, wdata0=0xBEEF -> ram_write_enable one cycle at addr 0x123, ack0 2 cycles after sampling.
REQ-028 Read-back: req1=1, we1=0, addr1=0x123 -> ack1 3 cycles after sampling, rdata1=0xBEEF, rdata0 unchanged.
REQ-029 Contention after reset: req0 and req1 raised same cycle, repeated 4 times -> grants alternate 0,1,0,1.
REQ-030 Boundary: write 0xA5A5 to 0x7FF and 0x5A5A to 0x000, read both -> 0xA5A5 and 0x5A5A returned, no aliasing.
REQ-031 Reset in READ_WAIT -> no ack, busy=0 and ram_write_enable=0 asynchronously, next request served normally.
